score_bcd_converter: RTL and testbench
======================================

# score_bcd_converter

Sequential binary-to-BCD converter for the game score. Sits between the game-logic score accumulator (binary) and the draw stage, which renders the score as packed 4-bit decimal digits. Uses shift-and-add-3 (double dabble), one bit per clock, with a start/done handshake. Holds the last valid result stable on its output while the next conversion runs, so the display never shows a partial value.

## Interface
Parameters:
- INPUT_WIDTH, 12, width of the binary input.
- DECIMAL_DIGITS, 4, number of BCD digits produced. The output is 4*DECIMAL_DIGITS bits wide.

Ports:
- clk  input  1  single clock for the block.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- bin_in  input  INPUT_WIDTH  unsigned binary score. Sampled only when a start is accepted.
- start  input  1  conversion request. Level-sensitive and accepted only in IDLE. May be tied high for continuous conversion.
- bcd_out  output  4*DECIMAL_DIGITS  packed BCD, most-significant digit in the top nibble. Registered.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out has just been updated.
- overflow  output  1  registered with bcd_out. High when the last converted value was ≥ 10^DECIMAL_DIGITS.

## Operation
- FSM states: IDLE and SHIFT. The reset state is IDLE.
- IDLE:
  - If start=1, latch bin_in into the shift register and clear the BCD scratch register and the bit counter.
  - Set busy=1 and go to SHIFT.
- SHIFT:
  - Each cycle, add 3 to every scratch nibble ≥ 5.
  - Then shift {scratch, shift register} left by one and increment the counter.
  - On the INPUT_WIDTH-th shift, commit the result to bcd_out, pulse done, clear busy and return to IDLE.
- Overflow handling:
  - A compare of the latched input against the elaboration-time constant 10^DECIMAL_DIGITS−1 is computed at start.
  - If the input exceeds that constant, the committed bcd_out is all-9 nibbles and overflow=1. Otherwise overflow=0.
  - With the default parameters (4095 < 9999) overflow never asserts.
- Scratch register width is 4*DECIMAL_DIGITS. Carries out of the top nibble are discarded; this is only reachable in the overflow case, which is saturated anyway.
- A start asserted while busy=1 is ignored and not queued. bin_in changes during SHIFT have no effect.
- Reset:
  - bcd_out=0, overflow=0, done=0, busy=0, state=IDLE.
  - A reset during SHIFT aborts the conversion. No done pulse is produced and bcd_out is cleared to 0.
- Counter width is clog2(INPUT_WIDTH+1). INPUT_WIDTH ≥ 1.

## Timing
- Start is accepted at edge E0. busy is high from E0 until edge E(INPUT_WIDTH), where the final shift happens.
- bcd_out, overflow and done update at E(INPUT_WIDTH), giving a latency of INPUT_WIDTH cycles. This is 12 cycles at the defaults.
- done is high for exactly the one cycle following E(INPUT_WIDTH). busy is low in that same cycle.
- A start sampled in that cycle (state IDLE) is accepted. Back-to-back throughput is therefore one result every INPUT_WIDTH+1 cycles; with start tied high, done pulses every 13 cycles at the defaults.
- bcd_out changes only on done edges or on reset, never mid-conversion.
- Reset takes priority over start on the same edge.

## Test plan
- Reset, then bin_in=1234 with start pulsed for 1 cycle → busy for 12 cycles; done pulse; bcd_out=16'h1234, overflow=0. bcd_out stays 16'h0000 until the done edge.
- bin_in=0 → bcd_out=16'h0000. bin_in=4095 → bcd_out=16'h4095. bin_in=9 → 16'h0009. bin_in=10 → 16'h0010.
- start held high, bin_in changed 5→999 in mid-conversion:
  - The first done gives 16'h0005. The next done, 13 cycles later, gives 16'h0999.
  - done pulses are exactly 13 cycles apart.
- A start pulse at cycles 3 and 7 of a conversion of 42 → a single done, bcd_out=16'h0042. No extra conversion follows.
- rst low at cycle 6 of a conversion of 777 → no done; bcd_out=0, busy=0 the next cycle. A new start afterwards converts correctly.
- Override INPUT_WIDTH=14 with bin_in=12000 → bcd_out=16'h9999, overflow=1. A following conversion of 9999 → bcd_out=16'h9999, overflow=0.

Source files
------------

// File: rtl/score_bcd_converter_if.sv
// Score conversion bus: binary score and start request in, packed BCD and status out.
interface score_bcd_converter_if #(
  parameter int INPUT_WIDTH    = 12,
  parameter int DECIMAL_DIGITS = 4
);
  logic [INPUT_WIDTH-1:0]      bin_in;
  logic                        start;
  logic [4*DECIMAL_DIGITS-1:0] bcd_out;
  logic                        busy;
  logic                        done;
  logic                        overflow;

  modport master (output bin_in, start, input bcd_out, busy, done, overflow);
  modport slave  (input bin_in, start, output bcd_out, busy, done, overflow);
endinterface

// File: rtl/score_bcd_converter.sv
// Bit-serial double-dabble binary-to-BCD converter; the previous result stays on
// bcd_out until the next conversion commits, so the display never sees a partial value.
module score_bcd_converter #(
  parameter int INPUT_WIDTH    = 12,
  parameter int DECIMAL_DIGITS = 4
) (
  input logic                  clk,
  input logic                  rst,
  score_bcd_converter_if.slave bus
);

  localparam int BCD_W = 4 * DECIMAL_DIGITS;
  localparam int CNT_W = $clog2(INPUT_WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]      MAX_DEC  = pow10(DECIMAL_DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(INPUT_WIDTH - 1);
  localparam logic [BCD_W-1:0] ALL_NINE = {DECIMAL_DIGITS{4'h9}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q, state_next;
  logic [INPUT_WIDTH-1:0]  shift_q, shift_next;
  logic [BCD_W-1:0]        scratch_q, scratch_next;
  logic [CNT_W-1:0]        count_q, count_next;
  logic                    ovf_pend_q, ovf_pend_next;
  logic [BCD_W-1:0]        bcd_q, bcd_next;
  logic                    ovf_q, ovf_next;
  logic                    busy_q, busy_next;
  logic                    done_q, done_next;
  logic [BCD_W-1:0]        adjusted;
  logic [BCD_W+INPUT_WIDTH-1:0] shifted;
  logic [63:0]             bin_wide;

  assign bin_wide = 64'(bus.bin_in);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_next;
      shift_q    <= shift_next;
      scratch_q  <= scratch_next;
      count_q    <= count_next;
      ovf_pend_q <= ovf_pend_next;
      bcd_q      <= bcd_next;
      ovf_q      <= ovf_next;
      busy_q     <= busy_next;
      done_q     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_q;
    shift_next    = shift_q;
    scratch_next  = scratch_q;
    count_next    = count_q;
    ovf_pend_next = ovf_pend_q;
    bcd_next      = bcd_q;
    ovf_next      = ovf_q;
    busy_next     = busy_q;
    done_next     = 1'b0;
    adjusted      = scratch_q;

    // Add-3 correction keeps every nibble a valid decimal digit after the doubling shift.
    for (int i = 0; i < DECIMAL_DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    shifted = {adjusted, shift_q} << 1;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_next    = bus.bin_in;
          scratch_next  = '0;
          count_next    = '0;
          ovf_pend_next = (bin_wide > MAX_DEC);
          busy_next     = 1'b1;
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_next = shifted[BCD_W+INPUT_WIDTH-1 -: BCD_W];
        shift_next   = shifted[INPUT_WIDTH-1:0];
        count_next   = count_q + CNT_W'(1);
        if (count_q == LAST_BIT) begin
          bcd_next   = ovf_pend_q ? ALL_NINE : shifted[BCD_W+INPUT_WIDTH-1 -: BCD_W];
          ovf_next   = ovf_pend_q;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter: a 12-bit and a 14-bit instance checked every
// cycle against a transaction-level decimal model, plus literal expectations per scenario.
module tb_score_bcd_converter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   errors = 0;
  bit   model_live = 1'b0;

  always #5 clk = ~clk;

  score_bcd_converter_if #(.INPUT_WIDTH(12), .DECIMAL_DIGITS(4)) if_a ();
  score_bcd_converter_if #(.INPUT_WIDTH(14), .DECIMAL_DIGITS(4)) if_b ();

  score_bcd_converter #(.INPUT_WIDTH(12), .DECIMAL_DIGITS(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  score_bcd_converter #(.INPUT_WIDTH(14), .DECIMAL_DIGITS(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  // Model state per instance: a conversion is just "value captured, N cycles left".
  bit          m_busy [2];
  bit          m_done [2];
  bit          m_ovf  [2];
  logic [15:0] m_bcd  [2];
  int          m_left [2];
  int          m_val  [2];

  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r;
    r = 16'h0000;
    if (v > 9999) return 16'h9999;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic modelStep(input int k, input logic start_v, input int bin_v, input int width);
    if (!rst) begin
      m_busy[k] = 1'b0; m_done[k] = 1'b0; m_ovf[k] = 1'b0; m_bcd[k] = 16'h0000; m_left[k] = 0;
    end else if (m_busy[k]) begin
      m_done[k] = 1'b0;
      m_left[k] = m_left[k] - 1;
      if (m_left[k] == 0) begin
        m_busy[k] = 1'b0;
        m_done[k] = 1'b1;
        m_bcd[k]  = model_bcd(m_val[k]);
        m_ovf[k]  = (m_val[k] > 9999);
      end
    end else begin
      m_done[k] = 1'b0;
      if (start_v) begin
        m_busy[k] = 1'b1;
        m_left[k] = width;
        m_val[k]  = bin_v;
      end
    end
  endtask

  always @(posedge clk) begin
    modelStep(0, if_a.start, int'(if_a.bin_in), 12);
    modelStep(1, if_b.start, int'(if_b.bin_in), 14);
    model_live = 1'b1;
  end

  task automatic cmpCycle(input string name, input int k, input logic [15:0] bcd,
                          input logic ovf, input logic busy, input logic done);
    tests++;
    if (bcd !== m_bcd[k] || ovf !== m_ovf[k] || busy !== m_busy[k] || done !== m_done[k]) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got bcd=%h ovf=%b busy=%b done=%b, want bcd=%h ovf=%b busy=%b done=%b",
               name, $time, bcd, ovf, busy, done, m_bcd[k], m_ovf[k], m_busy[k], m_done[k]);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      cmpCycle("cycle_a", 0, if_a.bcd_out, if_a.overflow, if_a.busy, if_a.done);
      cmpCycle("cycle_b", 1, if_b.bcd_out, if_b.overflow, if_b.busy, if_b.done);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input int value);
    @(negedge clk);
    if (sel == 0) begin if_a.bin_in = 12'(value); if_a.start = 1'b1; end
    else          begin if_b.bin_in = 14'(value); if_b.start = 1'b1; end
    @(negedge clk);
    if_a.start = 1'b0;
    if_b.start = 1'b0;
  endtask

  task automatic waitDone(input int sel, input string name, output int cycles);
    cycles = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if ((sel == 0 && if_a.done) || (sel == 1 && if_b.done)) begin
        cycles = n;
        return;
      end
    end
    tests++;
    errors++;
    $display("[TB] FAIL %s: done not seen within 40 cycles, want a done pulse", name);
  endtask

  task automatic convertA(input string name, input int value, input logic [15:0] exp);
    int cyc;
    applyStimulus(0, value);
    waitDone(0, name, cyc);
    checkOutput({name, "_latency"}, 32'(cyc), 32'd12);
    checkOutput({name, "_bcd"}, 32'(if_a.bcd_out), 32'(exp));
    checkOutput({name, "_ovf"}, 32'(if_a.overflow), 32'd0);
  endtask

  initial begin
    int cyc;
    if_a.bin_in = '0; if_a.start = 1'b0;
    if_b.bin_in = '0; if_b.start = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_bcd",  32'(if_a.bcd_out), 32'h0);
    checkOutput("reset_busy", 32'({if_a.busy, if_a.done, if_a.overflow}), 32'h0);
    rst = 1'b1;

    convertA("conv_1234", 1234, 16'h1234);
    convertA("conv_0",    0,    16'h0000);
    convertA("conv_4095", 4095, 16'h4095);
    convertA("conv_9",    9,    16'h0009);
    convertA("conv_10",   10,   16'h0010);

    // Start held high: the mid-conversion input change only affects the next result.
    @(negedge clk);
    if_a.bin_in = 12'd5;
    if_a.start  = 1'b1;
    repeat (4) @(negedge clk);
    if_a.bin_in = 12'd999;
    waitDone(0, "hold_first", cyc);
    checkOutput("hold_first_bcd", 32'(if_a.bcd_out), 32'h0005);
    waitDone(0, "hold_second", cyc);
    if_a.start = 1'b0;
    checkOutput("hold_period", 32'(cyc), 32'd13);
    checkOutput("hold_second_bcd", 32'(if_a.bcd_out), 32'h0999);
    repeat (16) @(negedge clk);

    applyStimulus(0, 42);
    repeat (3) @(negedge clk);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    repeat (3) @(negedge clk);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    waitDone(0, "ignore_start", cyc);
    checkOutput("ignore_start_bcd", 32'(if_a.bcd_out), 32'h0042);
    repeat (20) @(negedge clk);
    checkOutput("ignore_start_idle", 32'({if_a.busy, if_a.done}), 32'h0);

    applyStimulus(0, 777);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("abort_bcd",  32'(if_a.bcd_out), 32'h0);
    checkOutput("abort_busy", 32'({if_a.busy, if_a.done}), 32'h0);
    repeat (15) @(negedge clk);
    convertA("after_abort", 321, 16'h0321);

    applyStimulus(1, 12000);
    waitDone(1, "wide_ovf", cyc);
    checkOutput("wide_ovf_latency", 32'(cyc), 32'd14);
    checkOutput("wide_ovf_bcd", 32'(if_b.bcd_out), 32'h9999);
    checkOutput("wide_ovf_flag", 32'(if_b.overflow), 32'd1);
    applyStimulus(1, 9999);
    waitDone(1, "wide_9999", cyc);
    checkOutput("wide_9999_bcd", 32'(if_b.bcd_out), 32'h9999);
    checkOutput("wide_9999_flag", 32'(if_b.overflow), 32'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
